// File: rtl/imac_pkg.sv
// Shared definitions for the integer multiply-accumulate datapath.
// The adder stage and the partial-sum accumulator both import this package.
package imac_pkg;

  // Default width of one partial sum: the 6-bit output of the 5-bit adder.
  localparam int IMAC_IN_W      = 6;
  // Default number of partial sums folded into one result.
  localparam int IMAC_NUM_TERMS = 16;

  // Accumulator control states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } acc_state_e;

  // Result width that cannot overflow: each term is below 2^in_w and there
  // are at most 2^clog2(n) of them.
  function automatic int acc_width(input int in_w, input int n);
    return in_w + $clog2(n);
  endfunction

endpackage

// File: rtl/partial_sum_accumulator.sv
// Folds NUM_TERMS unsigned partial sums into one exact result, then holds
// that result on a valid/ready output until downstream takes it.
module partial_sum_accumulator
  import imac_pkg::*;
#(
  parameter int IN_W      = IMAC_IN_W,
  parameter int NUM_TERMS = IMAC_NUM_TERMS,
  parameter int ACC_W     = acc_width(IN_W, NUM_TERMS),
  parameter int CNT_W     = $clog2(NUM_TERMS) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [ACC_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] term_cnt
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_TERMS - 1);

  acc_state_e       state;
  logic [ACC_W-1:0] acc;
  logic             in_hs;
  logic             last_term;

  // A term is taken only while the block advertises space (never in HOLD).
  assign in_hs     = in_valid & in_ready;
  // The handshake that brings the count to NUM_TERMS closes the result.
  assign last_term = (term_cnt == LAST_CNT);
  assign out_data  = acc;

  // Control FSM with registered handshake outputs; rst beats clear beats
  // any handshake, so a term offered alongside clear is simply dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      acc       <= '0;
      term_cnt  <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else if (clear) begin
      state     <= ST_IDLE;
      acc       <= '0;
      term_cnt  <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_hs) begin
            acc      <= ACC_W'(in_data);
            term_cnt <= CNT_W'(1);
            if (NUM_TERMS == 1) begin
              state     <= ST_HOLD;
              out_valid <= 1'b1;
              in_ready  <= 1'b0;
            end else begin
              state <= ST_ACCUM;
            end
          end
        end
        ST_ACCUM: begin
          // Gaps (in_valid low) leave acc and term_cnt untouched.
          if (in_hs) begin
            acc      <= acc + ACC_W'(in_data);
            term_cnt <= term_cnt + CNT_W'(1);
            if (last_term) begin
              state     <= ST_HOLD;
              out_valid <= 1'b1;
              in_ready  <= 1'b0;
            end
          end
        end
        ST_HOLD: begin
          // Result stays put until taken; the next accumulation starts from
          // an empty accumulator so out_data reads zero while idle.
          if (out_ready) begin
            state     <= ST_IDLE;
            acc       <= '0;
            term_cnt  <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= ST_IDLE;
          acc       <= '0;
          term_cnt  <= '0;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_partial_sum_accumulator.sv
// Randomized and directed bench for partial_sum_accumulator against a
// transaction-level model: a queue of accepted terms plus a "result held" flag.
module tb_partial_sum_accumulator;
  import imac_pkg::*;

  localparam int IN_W  = IMAC_IN_W;
  localparam int N     = IMAC_NUM_TERMS;
  localparam int ACC_W = acc_width(IN_W, N);
  localparam int CNT_W = $clog2(N) + 1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             clear = 1'b0;
  logic [IN_W-1:0]  in_data = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [ACC_W-1:0] out_data;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [CNT_W-1:0] term_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state.
  int  terms[$];
  bit  m_hold  = 1'b0;
  bit  m_known = 1'b0;  // idle accumulator value is defined (after rst/clear)

  partial_sum_accumulator #(.IN_W(IN_W), .NUM_TERMS(N)) dut (
    .clk(clk), .rst(rst), .clear(clear),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .term_cnt(term_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int model_sum();
    int s = 0;
    foreach (terms[i]) s += terms[i];
    return s;
  endfunction

  // One clock: predict from current inputs, advance, then compare outputs.
  task automatic cycle();
    if (rst || clear) begin
      terms.delete();
      m_hold  = 1'b0;
      m_known = 1'b1;
    end else if (m_hold) begin
      if (out_ready) begin
        terms.delete();
        m_hold  = 1'b0;
        m_known = 1'b0;
      end
    end else if (in_valid) begin
      terms.push_back(int'(in_data));
      if (terms.size() == N) m_hold = 1'b1;
    end
    @(posedge clk);
    #1;
    chk("out_valid", int'(out_valid), int'(m_hold));
    chk("in_ready", int'(in_ready), int'(!m_hold));
    chk("term_cnt", int'(term_cnt), terms.size());
    if (terms.size() > 0 || m_known) chk("out_data", int'(out_data), model_sum());
  endtask

  task automatic idle_inputs();
    rst = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
  endtask

  task automatic send(input int v);
    in_valid = 1'b1;
    in_data  = IN_W'(v);
    cycle();
    in_valid = 1'b0;
  endtask

  initial begin
    int saved;

    // Reset state.
    idle_inputs();
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_in_ready", int'(in_ready), 1);

    // Back-to-back maximum terms: exact 1008 one cycle after the 16th.
    for (int i = 0; i < N; i++) begin
      chk("max_no_valid_early", int'(out_valid), 0);
      send(63);
    end
    chk("max_result", int'(out_data), N * 63);
    chk("max_valid", int'(out_valid), 1);
    chk("max_in_ready", int'(in_ready), 0);
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;

    // Terms 1..N with random gaps.
    for (int i = 1; i <= N; i++) begin
      int gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) cycle();
      chk("gap_cnt_before", int'(term_cnt), i - 1);
      send(i);
    end
    chk("gap_result", int'(out_data), N * (N + 1) / 2);

    // Stall in HOLD for 10 cycles with stray in_valid pulses.
    saved = int'(out_data);
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      in_data  = IN_W'($urandom);
      cycle();
      chk("stall_data", int'(out_data), saved);
      chk("stall_in_ready", int'(in_ready), 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    send(9);
    chk("fresh_start", int'(out_data), 9);
    for (int i = 1; i < N; i++) send(0);
    chk("fresh_result", int'(out_data), 9);
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;

    // clear mid-accumulation with a term offered in the same cycle.
    for (int i = 0; i < 7; i++) send(5);
    chk("pre_clear_acc", int'(out_data), 35);
    clear = 1'b1;
    send(7);
    clear = 1'b0;
    chk("clear_acc", int'(out_data), 0);
    chk("clear_cnt", int'(term_cnt), 0);
    for (int i = 0; i < N; i++) send(1);
    chk("post_clear_result", int'(out_data), N);

    // rst in HOLD alongside out_ready.
    out_ready = 1'b1;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    out_ready = 1'b0;
    chk("rst_hold_valid", int'(out_valid), 0);
    chk("rst_hold_data", int'(out_data), 0);
    chk("rst_hold_cnt", int'(term_cnt), 0);

    // clear in HOLD discards the result.
    for (int i = 0; i < N; i++) send(2);
    clear = 1'b1;
    cycle();
    clear = 1'b0;
    chk("clear_hold_valid", int'(out_valid), 0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = IN_W'($urandom);
      out_ready = ($urandom_range(0, 2) == 0);
      clear     = ($urandom_range(0, 199) == 0);
      rst       = ($urandom_range(0, 399) == 0);
      cycle();
    end
    idle_inputs();
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
